// File: rtl/trail_mem_arbiter_pkg.sv
// Shared types and constants for the trail/frame memory arbiter and the trail
// writers that sit in front of it.
//   TM_*          default widths/sizes for the arbiter and its bus interface
//   REQ_*         requester index assignment on the arbiter
//   arb_state_t   arbiter FSM state, also exported on the debug port
//   trail_code_t  per-cell trail code stored in the frame memory
package trail_mem_pkg;

  localparam int TM_N_REQ     = 3;
  localparam int TM_ADDR_W    = 20;
  localparam int TM_DATA_W    = 16;
  localparam int TM_MAX_BURST = 64;

  localparam int REQ_CLEAR = 0;
  localparam int REQ_BLUE  = 1;
  localparam int REQ_RED   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

  typedef enum logic [2:0] {
    TRAIL_NONE = 3'd0,
    B_HORIZ    = 3'd1,
    B_VERT     = 3'd2,
    R_HORIZ    = 3'd3,
    R_VERT     = 3'd4,
    CORNER     = 3'd5
  } trail_code_t;

endpackage

// File: rtl/trail_mem_arbiter_if.sv
// Requester-side bus of the trail memory arbiter.
// Handshake: requester i raises req[i] and holds it for the whole burst. A beat
// transfers in every cycle where gnt[i] && valid[i]; there is no separate ready,
// gnt is the ready. last[i] on a transferring beat ends the burst; dropping
// req[i] while granted aborts it (a beat in that same cycle still transfers).
// Read data comes back as rvalid[i] one cycle after the read beat, with rdata
// broadcast to all requesters.
//   master : requester side (drives req/valid/last/wr/addr/wdata)
//   slave  : arbiter side (drives gnt/rvalid/rdata)
interface trail_mem_arbiter_if
  import trail_mem_pkg::*;
#(
  parameter int N_REQ  = TM_N_REQ,
  parameter int ADDR_W = TM_ADDR_W,
  parameter int DATA_W = TM_DATA_W
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        valid;
  logic [N_REQ-1:0]        last;
  logic [N_REQ-1:0]        wr;
  logic [N_REQ*ADDR_W-1:0] addr;
  logic [N_REQ*DATA_W-1:0] wdata;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        rvalid;
  logic [DATA_W-1:0]       rdata;

  modport master (
    output req, valid, last, wr, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, valid, last, wr, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/trail_mem_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req    : request vector
//   ptr    : index with highest priority this round
//   winner : one-hot of the first set req bit at or after ptr, wrapping
//   any    : at least one request present
module rr_pick #(
  parameter int N = 3,
  localparam int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     winner,
  output logic             any
);
  // Walk offsets from farthest to nearest so the nearest set bit overwrites.
  always_comb begin
    winner = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        winner = '0;
        winner[(int'(ptr) + k) % N] = 1'b1;
      end
    end
  end

  assign any = |req;
endmodule

// File: rtl/trail_mem_arbiter.sv
// Shares the single trail/frame memory port between burst requesters
// (0 = arena clear, 1 = blue trail, 2 = red trail). Round-robin, burst-locked
// grants; a burst ends on last, on req drop, or on a MAX_BURST watchdog.
//   Clk, Reset   : clock, synchronous active-high reset
//   arb_en       : allows new grants; a running burst is never cut by it
//   bus          : requester bus (slave side)
//   mem_*        : memory port; mem_rdata is valid 1 cycle after the address
//   err_timeout  : one-cycle pulse after a watchdog release
//   dbg_state    : FSM state, dbg_ptr : round-robin pointer
module trail_mem_arbiter
  import trail_mem_pkg::*;
#(
  parameter int N_REQ     = TM_N_REQ,
  parameter int ADDR_W    = TM_ADDR_W,
  parameter int DATA_W    = TM_DATA_W,
  parameter int MAX_BURST = TM_MAX_BURST,
  localparam int PTR_W    = $clog2(N_REQ),
  localparam int CNT_W    = $clog2(MAX_BURST)
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               arb_en,
  trail_mem_arbiter_if.slave bus,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  output logic               mem_we,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic               err_timeout,
  output arb_state_t         dbg_state,
  output logic [PTR_W-1:0]   dbg_ptr
);
  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rd_pend_q, rd_pend_d;
  logic [PTR_W-1:0] rd_owner_q, rd_owner_d;
  logic             to_q, to_d;

  logic [N_REQ-1:0] pick;
  logic             pick_any;
  logic [PTR_W-1:0] gidx;
  logic             bursting, g_valid, g_last, g_wr, g_req;
  logic             end_last, end_abort, end_timeout;

  rr_pick #(.N(N_REQ)) u_pick (
    .req    (bus.req),
    .ptr    (ptr_q),
    .winner (pick),
    .any    (pick_any)
  );

  always_comb begin
    gidx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_q[i]) gidx = PTR_W'(i);
    end
  end

  // Only the granted requester's controls are looked at; gating by BURST
  // keeps the memory port quiet (all zero) whenever nobody holds the grant.
  assign bursting = (state_q == BURST);
  assign g_valid  = bursting & bus.valid[gidx];
  assign g_last   = bus.last[gidx];
  assign g_wr     = bus.wr[gidx];
  assign g_req    = bus.req[gidx];

  assign mem_addr  = bursting ? bus.addr[int'(gidx)*ADDR_W +: ADDR_W]  : '0;
  assign mem_wdata = bursting ? bus.wdata[int'(gidx)*DATA_W +: DATA_W] : '0;
  assign mem_we    = g_valid & g_wr;

  assign end_last    = g_valid & g_last;
  assign end_abort   = ~g_req;
  assign end_timeout = (cnt_q == CNT_W'(MAX_BURST - 1)) & ~end_last;

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    to_d       = 1'b0;
    rd_pend_d  = g_valid & ~g_wr;
    rd_owner_d = (g_valid & ~g_wr) ? gidx : rd_owner_q;
    case (state_q)
      IDLE: begin
        if (arb_en && pick_any) begin
          gnt_d   = pick;
          cnt_d   = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        cnt_d = cnt_q + 1'b1;
        if (end_last || end_abort || end_timeout) begin
          gnt_d   = '0;
          ptr_d   = (gidx == PTR_W'(N_REQ - 1)) ? '0 : gidx + 1'b1;
          to_d    = end_timeout;
          state_d = GAP;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= '0;
      to_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
      to_q       <= to_d;
    end
  end

  // Memory returns read data one cycle after the address, so rdata is the
  // live memory output and rvalid just marks whose read it is.
  assign bus.gnt     = gnt_q;
  assign bus.rvalid  = rd_pend_q ? (N_REQ'(1) << rd_owner_q) : '0;
  assign bus.rdata   = mem_rdata;
  assign err_timeout = to_q;
  assign dbg_state   = state_q;
  assign dbg_ptr     = ptr_q;
endmodule
